// File: rtl/alu_mc_core.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops plus an iterative unsigned
// restoring divider. Results and flags are held in an output register with valid/ready.
module alu_mc_core #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag,
  output logic             signFlag,
  output logic             busy
);
  // Handshake: a request is accepted on any rising edge where in_valid & in_ready;
  // a result is consumed on any rising edge where out_valid & out_ready.
  localparam logic [3:0] OP_DIV = 4'd0, OP_SRA = 4'd1, OP_ROR = 4'd2, OP_ROL = 4'd3,
                         OP_SGT = 4'd4, OP_OR = 4'd5, OP_AND = 4'd6, OP_MAX = 4'd7,
                         OP_SLT = 4'd8, OP_SGE = 4'd9, OP_NAND = 4'd10, OP_SLL = 4'd11;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {IDLE, DIV_RUN} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic             accept, div_start, div_last, wr_en;
  logic [WIDTH:0]   shifted, trial;
  logic             take;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] op_res, wr_res;
  logic             op_c, op_o, wr_c, wr_o;
  logic signed [WIDTH:0] sra_ext;
  logic [WIDTH:0]   sll_ext;
  logic [SHW-1:0]   rot;

  assign in_ready  = (state_q == IDLE) & (~out_valid | out_ready);
  assign busy      = (state_q == DIV_RUN);
  assign accept    = in_valid & in_ready;
  assign div_start = accept & (opcode == OP_DIV) & (input2 != '0);
  assign div_last  = (state_q == DIV_RUN) & (cnt_q == CW'(WIDTH - 1));
  assign wr_en     = (accept & ~div_start) | div_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_start) state_d = DIV_RUN;
      DIV_RUN: if (div_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One restoring step: remainder stays below the divisor, so bit WIDTH of trial is the borrow.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    take     = ~trial[WIDTH];
    rem_next = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], take};
  end

  always_comb begin
    // Extra bit beside the operand catches the last bit shifted out.
    sra_ext = $signed({input1, 1'b0}) >>> shiftValue;
    sll_ext = {1'b0, input1} << shiftValue;
    rot     = SHW'(shiftValue % WIDTH);
    op_res  = '0;
    op_c    = 1'b0;
    op_o    = 1'b0;
    case (opcode)
      OP_DIV:  op_o = 1'b1;
      OP_SRA:  begin op_res = sra_ext[WIDTH:1]; op_c = sra_ext[0]; end
      OP_SLL:  begin op_res = sll_ext[WIDTH-1:0]; op_c = sll_ext[WIDTH]; end
      OP_ROL:  begin
        op_res = (input1 << rot) | (input1 >> (WIDTH - int'(rot)));
        op_c   = (shiftValue != '0) & op_res[0];
      end
      OP_ROR:  begin
        op_res = (input1 >> rot) | (input1 << (WIDTH - int'(rot)));
        op_c   = (shiftValue != '0) & op_res[WIDTH-1];
      end
      OP_SGT:  op_res = WIDTH'($signed(input1) >  $signed(input2));
      OP_SLT:  op_res = WIDTH'($signed(input1) <  $signed(input2));
      OP_SGE:  op_res = WIDTH'($signed(input1) >= $signed(input2));
      OP_OR:   op_res = input1 | input2;
      OP_AND:  op_res = input1 & input2;
      OP_NAND: op_res = ~(input1 & input2);
      OP_MAX:  op_res = (input1 > input2) ? input1 : input2;
      default: op_res = '0;
    endcase
    wr_res = div_last ? quo_next : op_res;
    wr_c   = div_last ? 1'b0 : op_c;
    wr_o   = div_last ? 1'b0 : op_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dvs_q        <= '0;
      out_valid    <= 1'b0;
      result       <= '0;
      carryFlag    <= 1'b0;
      zeroFlag     <= 1'b0;
      overFlowFlag <= 1'b0;
      signFlag     <= 1'b0;
    end else begin
      if (div_start) begin
        cnt_q <= '0;
        quo_q <= input1;
        rem_q <= '0;
        dvs_q <= input2;
      end else if (state_q == DIV_RUN) begin
        cnt_q <= cnt_q + CW'(1);
        quo_q <= quo_next;
        rem_q <= rem_next;
      end
      if (wr_en) begin
        out_valid    <= 1'b1;
        result       <= wr_res;
        carryFlag    <= wr_c;
        zeroFlag     <= (wr_res == '0);
        overFlowFlag <= wr_o;
        signFlag     <= wr_res[WIDTH-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_mc_core.md
ALU_MC_CORE -- requirements
Module: alu_mc_core

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; legal values 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opcode  input  4  DIV=0 SRA=1 ROR=2 ROL=3 SGT=4 OR=5 AND=6 MAX=7 SLT=8 SGE=9 NAND=10 SLL=11; 12-15 reserved.
REQ-008 input1, input2  input  WIDTH  operands, sampled on accept.
REQ-009 shiftValue  input  SHW  shift/rotate amount, sampled on accept.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 carryFlag, zeroFlag, overFlowFlag, signFlag  output  1 each  registered flags, aligned with result.
REQ-014 busy  output  1  high while a divide is iterating.

Function
REQ-015 Accept occurs on a cycle with in_valid & in_ready; operands and opcode are captured that cycle.
REQ-016 in_ready = (state==IDLE) & (!out_valid | out_ready); back-to-back single-cycle ops sustain one per cycle.
REQ-017 FSM states IDLE, DIV_RUN; IDLE->DIV_RUN on accepting DIV with input2!=0; DIV_RUN->IDLE after WIDTH iterations.
REQ-018 Non-DIV ops and DIV-by-zero: out_valid rises on the cycle after accept (latency 1).
REQ-019 DIV with nonzero divisor: unsigned restoring division, one quotient bit per cycle, out_valid rises WIDTH+1 cycles after accept; remainder discarded.
REQ-020 DIV with input2==0: result 0, overFlowFlag 1.
REQ-021 SRA arithmetic right shift; SLL logical left shift; ROL/ROR rotate by shiftValue modulo WIDTH.
REQ-022 SGT, SLT, SGE: signed two's-complement compare, result 1 if true else 0 (zero-extended).
REQ-023 OR, AND, NAND bitwise; MAX unsigned maximum.
REQ-024 Reserved opcodes: result 0, carry 0, overflow 0, zeroFlag 1, out_valid asserted normally.
REQ-025 carryFlag: SLL/SRA last bit shifted out; ROL = result[0]; ROR = result[WIDTH-1]; 0 if shiftValue==0 and for all other ops.
REQ-026 overFlowFlag: 1 only for DIV-by-zero.
REQ-027 zeroFlag = (result==0); signFlag = result[WIDTH-1]; both computed from the result being registered.
REQ-028 While out_valid & !out_ready, result and all flags hold stable and in_ready is 0.
REQ-029 out_valid clears on out_ready unless a new result is written the same cycle.
REQ-030 busy = (state==DIV_RUN); in_ready is 0 while busy.

Reset
REQ-031 rst_n low forces immediately: state IDLE, out_valid 0, busy 0, result 0, all flags 0; in_ready 1 after release.
REQ-032 Reset during DIV_RUN aborts the divide; no result is produced for it.
REQ-033 First accept possible on the first rising edge with rst_n high.

Verification
REQ-034 OR 0x00F0, 0x0F00 accepted cycle N -> out_valid at N+1, result 0x0FF0, zero 0, sign 0, carry 0.
REQ-035 DIV 1000/7 (WIDTH=16) accepted cycle N -> busy N+1..N+16, in_ready 0 throughout, out_valid at N+17, result 0x008E, overflow 0.
REQ-036 DIV 0x1234/0 -> out_valid at N+1, result 0x0000, zero 1, overflow 1, busy never asserted.
REQ-037 SRA 0x8001 by 1 -> 0xC000, carry 1, sign 1; SLT 0xFFFF vs 0x0001 -> 1; SGT same operands -> 0; SGE 0x8000 vs 0x8000 -> 1.
REQ-038 out_ready held low 3 cycles after a result -> result/flags unchanged, in_ready 0; on out_ready high, next request is accepted that same cycle.
REQ-039 rst_n pulsed low at 5th cycle of DIV_RUN -> out_valid 0, busy 0, result 0 immediately; after release in_ready 1 and no stale result ever appears.
